serial_subtractor: RTL and testbench

//  - Bit-serial, LSB-first two's-complement subtractor: o_result = i_min - i_sub.
//  - One full-subtractor cell plus a borrow flop, reused over WIDTH cycles.
//  - Area-lean counterpart to the parallel adder datapath.
//  - Handshake: start/busy/done. Sits beside the adder in the arithmetic lab datapath.

---
 rtl/serial_subtractor.sv | 144 ++++++++++++++
 tb/tb_serial_subtractor.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: o_result = {borrow, i_min - i_sub} over WIDTH cycles.
// Define SERIAL_SUB_ABS_EN to return {1, |i_min - i_sub|} for negative results (NEG pass).
module serial_subtractor #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_min,
  input  logic [WIDTH-1:0] i_sub,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH:0]   o_result
);

  localparam int unsigned CntW = $clog2(WIDTH);

`ifdef SERIAL_SUB_ABS_EN
  typedef enum logic [1:0] {StIdle, StRun, StNeg, StDone} state_e;
`else
  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;
`endif

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_q, b_q, diff_q;
  logic [CntW-1:0]  cnt_q;
  logic             bw_q;
  logic [WIDTH:0]   result_q;

  // Shared full-subtractor cell
  logic             d_bit, bw_nxt, last;
  logic [WIDTH-1:0] diff_shift;

  always_comb begin
    d_bit      = a_q[0] ^ b_q[0] ^ bw_q;
    bw_nxt     = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & bw_q);
    diff_shift = {d_bit, diff_q[WIDTH-1:1]};
    last       = (cnt_q == CntW'(WIDTH - 1));
  end

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (i_start) state_d = StRun;
      StRun: begin
        if (last) begin
`ifdef SERIAL_SUB_ABS_EN
          state_d = bw_nxt ? StNeg : StDone;
`else
          state_d = StDone;
`endif
        end
      end
`ifdef SERIAL_SUB_ABS_EN
      StNeg: if (last) state_d = StDone;
`endif
      StDone:  state_d = i_start ? StRun : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    o_busy   = 1'b0;
    o_done   = 1'b0;
    o_result = result_q;
    case (state_q)
      StRun:  o_busy = 1'b1;
`ifdef SERIAL_SUB_ABS_EN
      StNeg:  o_busy = 1'b1;
`endif
      StDone: o_done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: operand shifters, diff accumulator, borrow flop, bit counter, result
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      bw_q     <= 1'b0;
      result_q <= '0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (i_start) begin
            a_q   <= i_min;
            b_q   <= i_sub;
            bw_q  <= 1'b0;
            cnt_q <= '0;
          end
        end
        StRun: begin
          a_q    <= a_q >> 1;
          b_q    <= b_q >> 1;
          diff_q <= diff_shift;
          bw_q   <= bw_nxt;
          cnt_q  <= cnt_q + CntW'(1);
          if (last) begin
`ifdef SERIAL_SUB_ABS_EN
            if (bw_nxt) begin
              // Negate the raw difference: 0 - diff through the same cell
              a_q   <= '0;
              b_q   <= diff_shift;
              bw_q  <= 1'b0;
              cnt_q <= '0;
            end else begin
              result_q <= {1'b0, diff_shift};
            end
`else
            result_q <= {bw_nxt, diff_shift};
`endif
          end
        end
`ifdef SERIAL_SUB_ABS_EN
        StNeg: begin
          a_q    <= a_q >> 1;
          b_q    <= b_q >> 1;
          diff_q <= diff_shift;
          bw_q   <= bw_nxt;
          cnt_q  <= cnt_q + CntW'(1);
          if (last) result_q <= {1'b1, diff_shift};
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor (WIDTH=16), honouring SERIAL_SUB_ABS_EN.
module tb_serial_subtractor;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [W-1:0]  min_op, sub_op;
  logic          busy, done;
  logic [W:0]    result;

  int tests  = 0;
  int errors = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_start  (start),
    .i_min    (min_op),
    .i_sub    (sub_op),
    .o_busy   (busy),
    .o_done   (done),
    .o_result (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W:0] ref_result(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] raw;
    raw = {1'b0, a} - {1'b0, b};
`ifdef SERIAL_SUB_ABS_EN
    if (raw[W]) return {1'b1, b - a};
`endif
    return raw;
  endfunction

  function automatic int ref_lat(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef SERIAL_SUB_ABS_EN
    if (a < b) return 2 * W + 1;
`endif
    return W + 1;
  endfunction

  // Issue one op; lat = edges from accept until o_done is captured, busy_n = busy cycles
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, output logic [W:0] res,
                        output int lat, output int busy_n, output bit seen);
    @(negedge clk);
    min_op = a;
    sub_op = b;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    lat    = 1;
    busy_n = busy ? 1 : 0;
    while (!done && lat < 3 * W + 4) begin
      @(negedge clk);
      lat++;
      if (busy) busy_n++;
    end
    seen = done;
    res  = result;
  endtask

  logic [W:0]   res, res2;
  int           lat, busy_n, gap, n_done;
  bit           seen;
  logic [W-1:0] ra, rb;

  initial begin
    rst = 1'b1; start = 1'b0; min_op = '0; sub_op = '0;
    #2;
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);
    check("reset_result", 32'(result), 0);
    @(negedge clk);
    rst = 1'b0;

    // 7 - 5
    run_op(16'h0007, 16'h0005, res, lat, busy_n, seen);
    check("7m5_seen", 32'(seen), 1);
    check("7m5_result", 32'(res), 32'h0_0002);
    check("7m5_latency", lat, 17);
    check("7m5_busy_cycles", busy_n, 16);
    repeat (3) @(negedge clk);
    check("7m5_result_held", 32'(result), 32'h0_0002);
    check("idle_done_low", 32'(done), 0);

    // 5 - 7
    run_op(16'h0005, 16'h0007, res, lat, busy_n, seen);
`ifdef SERIAL_SUB_ABS_EN
    check("5m7_result", 32'(res), 32'h1_0002);
    check("5m7_latency", lat, 33);
`else
    check("5m7_result", 32'(res), 32'h1_FFFE);
    check("5m7_latency", lat, 17);
`endif

    run_op(16'hFFFF, 16'hFFFF, res, lat, busy_n, seen);
    check("equal_result", 32'(res), 32'h0_0000);

    run_op(16'h0000, 16'hFFFF, res, lat, busy_n, seen);
`ifdef SERIAL_SUB_ABS_EN
    check("zero_minus_max", 32'(res), 32'h1_FFFF);
`else
    check("zero_minus_max", 32'(res), 32'h1_0001);
`endif

    // i_start pulses at RUN cycles 3 and 9 must be ignored
    @(negedge clk);
    min_op = 16'h1234; sub_op = 16'h0034; start = 1'b1;
    @(negedge clk);
    start = 1'b0; n_done = 0; res = '0;
    for (int i = 1; i < 3 * W + 4; i++) begin
      if (i == 3 || i == 9) begin
        start = 1'b1; min_op = 16'hFFFF; sub_op = 16'h0001;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        if (n_done == 0) res = result;
        n_done++;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("ignore_start_ndone", n_done, 1);
    check("ignore_start_result", 32'(res), 32'h0_1200);

    // Back-to-back: start held high through DONE
    @(negedge clk);
    min_op = 16'h0100; sub_op = 16'h0001; start = 1'b1;
    @(negedge clk);
    min_op = 16'hABCD; sub_op = 16'h0BCD;
    lat = 1;
    while (!done && lat < 3 * W + 4) begin
      @(negedge clk);
      lat++;
    end
    check("b2b_first_result", 32'(result), 32'h0_00FF);
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
      if (gap == 1) start = 1'b0;
    end while (!done && gap < 3 * W + 4);
    check("b2b_gap", gap, 17);
    check("b2b_second_result", 32'(result), 32'h0_A000);

    // Async reset at RUN cycle 8
    @(negedge clk);
    min_op = 16'h00FF; sub_op = 16'h0001; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 0);
    check("midrst_done", 32'(done), 0);
    check("midrst_result", 32'(result), 0);
    n_done = 0;
    repeat (2) begin
      @(negedge clk);
      if (done) n_done++;
    end
    rst = 1'b0;
    repeat (W + 4) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("midrst_no_done", n_done, 0);
    run_op(16'h8000, 16'h0001, res, lat, busy_n, seen);
    check("post_rst_result", 32'(res), 32'h0_7FFF);
    check("post_rst_latency", lat, 17);

    // Random operand pairs
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if (i % 8 == 0) rb = ra;
      run_op(ra, rb, res, lat, busy_n, seen);
      check("rand_seen", 32'(seen), 1);
      check("rand_result", 32'(res), 32'(ref_result(ra, rb)));
      check("rand_latency", lat, ref_lat(ra, rb));
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
